// File: rtl/alu_operand_regfile.sv
// -----------------------------------------------------------------------------
// alu_operand_regfile
//
// Purpose:
//   Operand source and result sink for the ALU. A 32x32 general-purpose
//   register file with two combinational read ports that feed the ALU inputs
//   and one write-back port that accepts the ALU result or a multi-cycle result.
//   A per-register busy scoreboard records the destinations of issued
//   multi-cycle operations that have not yet written back. Stall is raised on
//   read-after-write hazards (a consumed operand is still pending) and on
//   write-after-write hazards (issuing to a register that is already pending).
//   Register 0 is hardwired to zero. It never becomes busy and never stalls.
//
// Ports:
//   clk        in   1     clock, rising-edge active
//   rst        in   1     asynchronous active-high reset
//   RdAddr1    in   AW    read port 1 address (rs)
//   RdUse1     in   1     port 1 operand consumed this cycle (hazard-checked)
//   RdData1    out  DW    read port 1 data (ALU DataIn1)
//   RdAddr2    in   AW    read port 2 address (rt)
//   RdUse2     in   1     port 2 operand consumed this cycle (hazard-checked)
//   RdData2    out  DW    read port 2 data (ALU DataIn2)
//   WrEn       in   1     write-back strobe (not gated by Stall)
//   WrAddr     in   AW    write-back destination
//   WrData     in   DW    write-back data
//   IssueEn    in   1     multi-cycle op issued this cycle
//   IssueAddr  in   AW    destination of the issued op
//   Stall      out  1     hazard; hold decode/issue this cycle
//   BusyVec    out  NREG  scoreboard snapshot, bit n = register n pending
//
// Configuration macro:
//   WB_BYPASS_EN  When defined, a write-back in the same cycle is forwarded to
//                 matching read ports (write-first). A register retiring this
//                 cycle also does not stall its consumer or a re-issue. When
//                 undefined, reads return the pre-edge array value, and the
//                 consumer stalls one extra cycle.
// -----------------------------------------------------------------------------
module alu_operand_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   RdAddr1,
    input  logic            RdUse1,
    output logic [DW-1:0]   RdData1,
    input  logic [AW-1:0]   RdAddr2,
    input  logic            RdUse2,
    output logic [DW-1:0]   RdData2,
    input  logic            WrEn,
    input  logic [AW-1:0]   WrAddr,
    input  logic [DW-1:0]   WrData,
    input  logic            IssueEn,
    input  logic [AW-1:0]   IssueAddr,
    output logic            Stall,
    output logic [NREG-1:0] BusyVec
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic wr_hit;
    logic issue_ok;
    logic clr1;
    logic clr2;
    logic clr_i;
    logic stall_c;

    logic [DW-1:0] arr_data1;
    logic [DW-1:0] arr_data2;

    // One-hot mask of a register address. Register 0 maps to an empty mask,
    // so scoreboard updates aimed at r0 fall away naturally.
    function automatic logic [NREG-1:0] addr_mask(input logic [AW-1:0] addr);
        logic [NREG-1:0] m;
        m = '0;
        if (addr != '0) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

    // Pending lookup. Register 0 is never pending.
    function automatic logic is_busy(input logic [NREG-1:0] vec,
                                     input logic [AW-1:0]   addr);
        return (addr != '0) && vec[addr];
    endfunction

    // Array read with register 0 forced to zero.
    function automatic logic [DW-1:0] gate_zero(input logic [AW-1:0] addr,
                                                input logic [DW-1:0] value);
        return (addr == '0) ? '0 : value;
    endfunction

    assign wr_hit = WrEn && (WrAddr != '0);

    // A write-back that retires in this cycle can satisfy a hazard only when
    // its data is forwarded. Without forwarding the consumer must wait until
    // the array holds the value.
`ifdef WB_BYPASS_EN
    assign clr1  = wr_hit && (WrAddr == RdAddr1);
    assign clr2  = wr_hit && (WrAddr == RdAddr2);
    assign clr_i = wr_hit && (WrAddr == IssueAddr);
`else
    assign clr1  = 1'b0;
    assign clr2  = 1'b0;
    assign clr_i = 1'b0;
`endif

    always_comb begin
        stall_c = 1'b0;
        if (RdUse1 && is_busy(busy, RdAddr1) && !clr1) begin
            stall_c = 1'b1;
        end
        if (RdUse2 && is_busy(busy, RdAddr2) && !clr2) begin
            stall_c = 1'b1;
        end
        if (IssueEn && is_busy(busy, IssueAddr) && !clr_i) begin
            stall_c = 1'b1;
        end
    end

    assign Stall = stall_c;

    // A stalled issue is dropped; upstream re-presents it.
    assign issue_ok = IssueEn && !stall_c && (IssueAddr != '0);

    // The clear from write-back is applied first and the set from issue last.
    // When both target the same register the new producer stays outstanding.
    always_comb begin
        busy_next = busy;
        if (wr_hit) begin
            busy_next = busy_next & ~addr_mask(WrAddr);
        end
        if (issue_ok) begin
            busy_next = busy_next | addr_mask(IssueAddr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign BusyVec = busy;

    // Register array. Register 0 is never written, so it holds its reset zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[WrAddr] <= WrData;
        end
    end

    always_comb begin
        arr_data1 = gate_zero(RdAddr1, regs[RdAddr1]);
        arr_data2 = gate_zero(RdAddr2, regs[RdAddr2]);
    end

`ifdef WB_BYPASS_EN
    // Write-first forwarding. clr1/clr2 already exclude register 0.
    assign RdData1 = clr1 ? WrData : arr_data1;
    assign RdData2 = clr2 ? WrData : arr_data2;
`else
    assign RdData1 = arr_data1;
    assign RdData2 = arr_data2;
`endif

endmodule
